// File: rtl/bus_master_ctrl_if.sv
// rtl/bus_master_ctrl_if.sv - shared-bus signal bundle between a master sequencer and the bus/arbiter
interface bus_master_ctrl_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              bus_req_;
  logic              bus_grnt_;
  logic              bus_as_;
  logic              bus_rw;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wr_data;
  logic [DATA_W-1:0] bus_rd_data;
  logic              bus_rdy_;

  modport master (
    output bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data,
    input  bus_grnt_, bus_rd_data, bus_rdy_
  );

  modport slave (
    input  bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data,
    output bus_grnt_, bus_rd_data, bus_rdy_
  );
endinterface

// File: rtl/bus_master_ctrl.sv
// rtl/bus_master_ctrl.sv - per-master bus sequencer: request, address phase, ready wait with timeout/retry, optional lock
module bus_master_ctrl #(
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 32,
  parameter int TO_W      = 8,
  parameter int TIMEOUT   = 255,
  parameter int RT_W      = 2,
  parameter int MAX_RETRY = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               rw,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               lock,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [DATA_W-1:0]  rd_data,
  bus_master_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ADDR, S_WAIT, S_DONE, S_OWN
  } state_t;

  state_t            state_q, state_d;
  logic              rw_q;
  logic              lock_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic [RT_W-1:0]   retry_q;

  logic accept;
  logic to_hit;
  logic can_retry;

  assign accept    = start && (state_q == S_IDLE || state_q == S_OWN);
  assign to_hit    = (to_cnt_q == TO_W'(TIMEOUT - 1));
  assign can_retry = (int'(retry_q) < MAX_RETRY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rw_q     <= 1'b1;
      lock_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      to_cnt_q <= '0;
      retry_q  <= '0;
      err      <= 1'b0;
      rd_data  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rw_q    <= rw;
        lock_q  <= lock;
        addr_q  <= addr;
        wdata_q <= wr_data;
        retry_q <= '0;
      end
      if (state_q == S_ADDR) begin
        to_cnt_q <= '0;
      end
      if (state_q == S_WAIT) begin
        // slave ready takes priority over an expiring timeout in the same cycle
        if (!bus.bus_rdy_) begin
          if (rw_q) begin
            rd_data <= bus.bus_rd_data;
          end
          err <= 1'b0;
        end else if (to_hit) begin
          if (can_retry) begin
            retry_q <= retry_q + RT_W'(1);
          end else begin
            err <= 1'b1;
          end
        end else begin
          to_cnt_q <= to_cnt_q + TO_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_REQ;
      S_OWN: begin
        if (start) begin
          state_d = bus.bus_grnt_ ? S_REQ : S_ADDR;
        end else if (!lock) begin
          state_d = S_IDLE;
        end
      end
      S_REQ:  if (!bus.bus_grnt_) state_d = S_ADDR;
      S_ADDR: state_d = S_WAIT;
      S_WAIT: begin
        if (!bus.bus_rdy_) begin
          state_d = S_DONE;
        end else if (to_hit) begin
          state_d = can_retry ? S_ADDR : S_DONE;
        end
      end
      S_DONE: state_d = lock_q ? S_OWN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy            = 1'b0;
    done            = 1'b0;
    bus.bus_req_    = 1'b1;
    bus.bus_as_     = 1'b1;
    bus.bus_rw      = 1'b1;
    bus.bus_addr    = '0;
    bus.bus_wr_data = '0;
    case (state_q)
      S_REQ: begin
        busy         = 1'b1;
        bus.bus_req_ = 1'b0;
      end
      S_ADDR, S_WAIT: begin
        busy            = 1'b1;
        bus.bus_req_    = 1'b0;
        bus.bus_as_     = (state_q != S_ADDR);
        bus.bus_rw      = rw_q;
        bus.bus_addr    = addr_q;
        bus.bus_wr_data = wdata_q;
      end
      S_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        bus.bus_req_ = !lock_q;
      end
      S_OWN:   bus.bus_req_ = !lock_q;
      default: bus.bus_req_ = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_bus_master_ctrl.sv
// tb/tb_bus_master_ctrl.sv - vector table, corner sequences and random commands against a latency/outcome model
module tb_bus_master_ctrl;
  localparam int TO = 4;
  localparam int MR = 1;

  logic        clk = 1'b0;
  logic        reset, start, rw, lock;
  logic [29:0] addr;
  logic [31:0] wr_data;
  logic        busy, done, err;
  logic [31:0] rd_data;

  int checks = 0;
  int failures = 0;

  bus_master_ctrl_if #(.ADDR_W(30), .DATA_W(32)) bus ();

  bus_master_ctrl #(
    .ADDR_W(30), .DATA_W(32), .TO_W(8), .TIMEOUT(TO), .RT_W(2), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wr_data(wr_data),
    .lock(lock), .busy(busy), .done(done), .err(err), .rd_data(rd_data), .bus(bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [29:0] a;
    logic [31:0] wd;
    logic        lk;
    logic        skip;
    int          h;
    int          k0;
    int          k1;
    logic [31:0] rdv;
    int          lat;
    logic        e;
    int          pulses;
    int          span;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // k0/k1: WAIT cycle (1-based) on which the slave pulls bus_rdy_ low for attempt 1/2
  task automatic run_cmd(input logic r, input logic [29:0] a, input logic [31:0] wd, input logic lk,
                         input logic skip, input int h, input int k0, input int k1,
                         input logic [31:0] rdv, output int lat, output logic e, output int pulses,
                         output int span, output logic req_ok, output logic addr_ok,
                         output logic req_done);
    int   cnt;
    int   p0;
    logic got;
    start = 1'b1; rw = r; addr = a; wr_data = wd; lock = lk;
    bus.bus_grnt_ = !skip; bus.bus_rdy_ = 1'b1; bus.bus_rd_data = rdv;
    lat = -1; e = 1'b0; pulses = 0; span = 0; req_ok = 1'b1; addr_ok = 1'b1; req_done = 1'b0;
    cnt = 0; p0 = 0; got = 1'b0;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc < 80 && !got; cyc++) begin
      bus.bus_grnt_ = !skip && (cyc <= h);
      if (done) begin
        got = 1'b1; lat = cyc; e = err; req_done = bus.bus_req_;
      end else begin
        if (bus.bus_req_ !== 1'b0) req_ok = 1'b0;
        if (bus.bus_as_ === 1'b0) begin
          if (pulses == 1) span = cyc - p0;
          p0 = cyc; pulses++; cnt = 0;
          bus.bus_rdy_ = 1'b1;
        end else if (pulses > 0) begin
          cnt++;
          bus.bus_rdy_ = (cnt == ((pulses == 1) ? k0 : k1)) ? 1'b0 : 1'b1;
        end
        if (pulses > 0 && (bus.bus_addr !== a || bus.bus_wr_data !== wd || bus.bus_rw !== r))
          addr_ok = 1'b0;
      end
      tick();
    end
    bus.bus_rdy_ = 1'b1;
    bus.bus_grnt_ = 1'b1;
  endtask

  // Outcome from the protocol rules: REQ cycles, then per attempt one address cycle
  // plus min(k, TIMEOUT) wait cycles; retries up to MR after a timed-out attempt.
  task automatic model(input logic skip, input int h, input int k0, input int k1,
                       output int lat, output logic e, output int pulses, output int span);
    int ks[2];
    ks[0] = k0; ks[1] = k1;
    lat = skip ? 1 : 2 + h;
    e = 1'b1; pulses = 0; span = 0;
    for (int at = 0; at <= MR; at++) begin
      pulses++;
      if (ks[at] <= TO) begin
        lat += 1 + ks[at];
        e = 1'b0;
        break;
      end
      lat += 1 + TO;
      if (at == 0) span = 1 + TO;
    end
  endtask

  task automatic compare(input string tag, input int lat, input int xlat, input logic e,
                         input logic xe, input int p, input int xp, input int sp, input int xsp,
                         input logic req_ok, input logic addr_ok, input logic req_done,
                         input logic lk, input logic [31:0] xrd);
    chk({tag, "_latency"}, 64'(lat), 64'(xlat));
    chk({tag, "_err"}, 64'(e), 64'(xe));
    chk({tag, "_as_pulses"}, 64'(p), 64'(xp));
    if (xp > 1) chk({tag, "_retry_span"}, 64'(sp), 64'(xsp));
    chk({tag, "_req_held"}, 64'(req_ok), 64'(1));
    chk({tag, "_bus_fields"}, 64'(addr_ok), 64'(1));
    chk({tag, "_req_in_done"}, 64'(req_done), 64'(!lk));
    chk({tag, "_rd_data"}, 64'(rd_data), 64'(xrd));
    chk({tag, "_busy_after"}, 64'(busy), 64'(0));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_err"}, 64'(err), 64'(0));
    chk({tag, "_rd_data"}, 64'(rd_data), 64'(0));
    chk({tag, "_req"}, 64'(bus.bus_req_), 64'(1));
    chk({tag, "_as"}, 64'(bus.bus_as_), 64'(1));
    chk({tag, "_rw"}, 64'(bus.bus_rw), 64'(1));
    chk({tag, "_addr"}, 64'(bus.bus_addr), 64'(0));
    chk({tag, "_wdata"}, 64'(bus.bus_wr_data), 64'(0));
  endtask

  initial begin
    int          lat, xlat, p, xp, sp, xsp, h, k0, k1, gaps;
    logic        e, xe, req_ok, addr_ok, req_done, own, r, lk, skip;
    logic [29:0] a;
    logic [31:0] wd, rdv, rd_exp;

    //              r     a            wd            lk    skip  h  k0 k1 rdv           lat e     p  span rd
    tbl[0] = '{1'b1, 30'h0000100, 32'h0,        1'b0, 1'b0, 0, 1, 1, 32'h12345678, 4,  1'b0, 1, 0, 32'h12345678};
    tbl[1] = '{1'b0, 30'h00002A0, 32'hDEADBEEF, 1'b0, 1'b0, 5, 2, 1, 32'h11111111, 10, 1'b0, 1, 0, 32'h12345678};
    tbl[2] = '{1'b0, 30'h00003F0, 32'h0BADF00D, 1'b1, 1'b0, 0, 1, 1, 32'h22222222, 4,  1'b0, 1, 0, 32'h12345678};
    tbl[3] = '{1'b1, 30'h00003F1, 32'h0,        1'b0, 1'b1, 0, 1, 1, 32'hCAFEF00D, 3,  1'b0, 1, 0, 32'hCAFEF00D};
    tbl[4] = '{1'b1, 30'h0000055, 32'h0,        1'b0, 1'b0, 0, 9, 9, 32'h33333333, 12, 1'b1, 2, 5, 32'hCAFEF00D};
    tbl[5] = '{1'b1, 30'h0000056, 32'h0,        1'b0, 1'b0, 0, 4, 1, 32'h0F0F0F0F, 7,  1'b0, 1, 0, 32'h0F0F0F0F};
    tbl[6] = '{1'b1, 30'h0000057, 32'h0,        1'b0, 1'b0, 0, 5, 2, 32'h00000077, 10, 1'b0, 2, 5, 32'h00000077};
    tbl[7] = '{1'b0, 30'h3FFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1, 9, 4, 32'h44444444, 13, 1'b0, 2, 5, 32'h00000077};

    reset = 1'b1; start = 1'b0; rw = 1'b0; lock = 1'b0; addr = '0; wr_data = '0;
    bus.bus_grnt_ = 1'b1; bus.bus_rdy_ = 1'b1; bus.bus_rd_data = '0;
    repeat (3) tick();
    chk_reset_vals("reset");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      if (i > 0 && tbl[i-1].lk) begin
        chk($sformatf("v%0d_own_req", i), 64'(bus.bus_req_), 64'(0));
        chk($sformatf("v%0d_own_busy", i), 64'(busy), 64'(0));
      end
      run_cmd(tbl[i].r, tbl[i].a, tbl[i].wd, tbl[i].lk, tbl[i].skip, tbl[i].h, tbl[i].k0,
              tbl[i].k1, tbl[i].rdv, lat, e, p, sp, req_ok, addr_ok, req_done);
      compare($sformatf("v%0d", i), lat, tbl[i].lat, e, tbl[i].e, p, tbl[i].pulses, sp,
              tbl[i].span, req_ok, addr_ok, req_done, tbl[i].lk, tbl[i].rd);
    end

    // start while busy must not disturb the captured command
    start = 1'b1; rw = 1'b1; addr = 30'h111; wr_data = '0; lock = 1'b0;
    bus.bus_grnt_ = 1'b0; bus.bus_rdy_ = 1'b1; bus.bus_rd_data = 32'h000000AB;
    tick();
    chk("busy_in_req", 64'(busy), 64'(1));
    start = 1'b1; addr = 30'h222; rw = 1'b0;
    tick();
    start = 1'b0;
    chk("busy_start_addr", 64'(bus.bus_addr), 64'(30'h111));
    chk("busy_start_rw", 64'(bus.bus_rw), 64'(1));
    tick();
    bus.bus_rdy_ = 1'b0;
    tick();
    bus.bus_rdy_ = 1'b1;
    chk("busy_start_done", 64'(done), 64'(1));
    tick();
    chk("busy_start_idle", 64'(busy), 64'(0));
    chk("busy_start_rd", 64'(rd_data), 64'(32'hAB));
    tick();
    chk("busy_start_no_second", 64'(busy), 64'(0));

    // reset while waiting on the slave
    start = 1'b1; rw = 1'b1; addr = 30'h1234; wr_data = 32'h5555AAAA; lock = 1'b1;
    bus.bus_grnt_ = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("wait_before_reset_busy", 64'(busy), 64'(1));
    chk("wait_before_reset_as", 64'(bus.bus_as_), 64'(1));
    reset = 1'b1; lock = 1'b0;
    tick();
    reset = 1'b0;
    chk_reset_vals("mid_reset");
    tick();
    chk("post_reset_idle", 64'(busy), 64'(0));
    bus.bus_grnt_ = 1'b1;

    own = 1'b0; rd_exp = '0;
    for (int n = 0; n < 40; n++) begin
      gaps = int'($urandom_range(0, 2));
      for (int g = 0; g < gaps; g++) begin
        chk($sformatf("r%0d_gap_busy", n), 64'(busy), 64'(0));
        chk($sformatf("r%0d_gap_req", n), 64'(bus.bus_req_), 64'(!own));
        lock = own && ($urandom_range(0, 3) != 0);
        tick();
        own = lock;
      end
      r = 1'($urandom); lk = ($urandom_range(0, 2) == 0); skip = own && 1'($urandom);
      a = 30'($urandom); wd = $urandom; rdv = $urandom;
      h = int'($urandom_range(0, 3)); k0 = int'($urandom_range(1, 6)); k1 = int'($urandom_range(1, 6));
      model(skip, h, k0, k1, xlat, xe, xp, xsp);
      if (r && !xe) rd_exp = rdv;
      run_cmd(r, a, wd, lk, skip, h, k0, k1, rdv, lat, e, p, sp, req_ok, addr_ok, req_done);
      compare($sformatf("r%0d", n), lat, xlat, e, xe, p, xp, sp, xsp, req_ok, addr_ok,
              req_done, lk, rd_exp);
      own = lk;
    end

    lock = 1'b0;
    tick();
    tick();
    chk("final_release", 64'(bus.bus_req_), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_master_ctrl.md
Name: bus_master_ctrl

Overview:
Per-master bus sequencer sitting between a client unit (CPU bus interface, DMA, UART) and the shared bus and its round-robin arbiter. It accepts one single-word read/write command, requests the bus, drives the address phase, and waits for slave ready with a timeout and bounded retry. An optional lock keeps bus ownership across back-to-back commands. Bus-side signals are active-low (`_` suffix), matching the bus protocol.

Parameters:
ADDR_W, 30, word address width
DATA_W, 32, data width
TO_W, 8, timeout counter width
TIMEOUT, 255, WAIT cycles with bus_rdy_ high before timeout; legal 1..2^TO_W-1
RT_W, 2, retry counter width
MAX_RETRY, 2, re-issues after timeout before error; legal 0..2^RT_W-1

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
start  in  1  command strobe, accepted only when busy=0
rw  in  1  1=read, 0=write
addr  in  ADDR_W  word address
wr_data  in  DATA_W  write data
lock  in  1  keep bus after this command / hold while idle in OWN
busy  out  1  command in progress
done  out  1  one-cycle completion pulse
err  out  1  valid with done: 1=timeout after all retries
rd_data  out  DATA_W  read result, held until next done
bus_req_  out  1  bus request to arbiter
bus_grnt_  in  1  grant from arbiter
bus_as_  out  1  address strobe
bus_rw  out  1  1=read, 0=write
bus_addr  out  ADDR_W  address
bus_wr_data  out  DATA_W  write data
bus_rd_data  in  DATA_W  slave read data
bus_rdy_  in  1  slave ready

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset (synchronous, any state, mid-transaction included): next state IDLE, pending command dropped.
- Reset values: busy=0, done=0, err=0, rd_data=0, bus_req_=1, bus_as_=1, bus_rw=1, bus_addr=0, bus_wr_data=0.
- States: IDLE, REQ, ADDR, WAIT, DONE, OWN.
- Command capture:
  - start with busy=0 (IDLE or OWN) registers rw, addr, wr_data, lock, and clears the retry count.
  - start with busy=1 is ignored.
- IDLE: on start -> REQ.
- OWN:
  - start and bus_grnt_=0 -> ADDR (REQ skipped).
  - start and bus_grnt_=1 -> REQ.
  - No start and lock=0 -> IDLE.
  - Otherwise stay.
- REQ: bus_req_=0. bus_grnt_ sampled low -> ADDR. No timeout.
- ADDR:
  - Exactly one cycle.
  - bus_as_=0, with bus_addr/bus_rw/bus_wr_data from the captured registers.
  - Clears the timeout counter. -> WAIT.
- WAIT:
  - bus_as_=1; bus_addr/bus_rw/bus_wr_data held.
  - bus_rdy_=0: rd_data<=bus_rd_data (reads only; writes leave rd_data unchanged), err<=0 -> DONE.
  - Else if counter==TIMEOUT-1:
    - retry count<MAX_RETRY: increment retry count -> ADDR.
    - Otherwise err<=1 -> DONE.
  - Else increment counter.
  - bus_rdy_=0 wins over timeout in the same cycle.
  - bus_grnt_ is ignored in WAIT.
- DONE: done=1 for one cycle -> OWN if captured lock=1, else IDLE.
- busy=1 in REQ, ADDR, WAIT, DONE; 0 in IDLE and OWN.
- bus_req_=0 in REQ/ADDR/WAIT. In DONE/OWN it is 0 if captured lock=1, else 1. It is 1 in IDLE.
- Bus outputs when not in ADDR/WAIT: bus_addr=0, bus_wr_data=0, bus_rw=1.
- Latency, no lock, immediate grant, zero-wait slave:
  - c0 start
  - c1 REQ
  - c2 ADDR
  - c3 WAIT (rdy_ low)
  - c4 DONE (done=1, bus_req_=1)
  - c5 IDLE

Test Plan:
- Read addr=0x0000100, grant low at c1, bus_rdy_=0 with bus_rd_data=0x12345678 at c3 -> bus_as_ low only at c2; done=1, err=0, rd_data=0x12345678, bus_req_=1 at c4; busy=0 at c5.
- Write 0xDEADBEEF, bus_grnt_ held high 5 cycles after REQ entry -> bus_req_ low throughout; bus_as_ low exactly one cycle, the cycle after grant is first sampled low; bus_wr_data=0xDEADBEEF during ADDR and WAIT.
- Write with lock=1, then read with lock=0 issued in OWN while granted -> ADDR the cycle after the second start, no REQ; bus_req_ continuously low; bus_req_=1 in the second DONE.
- TIMEOUT=4, MAX_RETRY=1, bus_rdy_ never low -> two bus_as_ pulses 5 cycles apart; done=1, err=1 one cycle after the 4th WAIT cycle of the second attempt; rd_data unchanged.
- TIMEOUT=4, bus_rdy_=0 on the 4th WAIT cycle -> success, err=0, no retry pulse.
- Reset asserted during WAIT -> next cycle IDLE with all outputs at reset values; start while busy=1 -> ignored, no change to captured addr.
